ex_mem_skid_reg: RTL and testbench
==================================

// Module: ex_mem_skid_reg
// PURPOSE
//  Parametrised EX->MEM pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush.
//  Sits between execute and memory stages. Adds stall back-pressure, bubble insertion and reset, which the
//  previous free-running stage register lacked. Keeps in_ready registered so MEM stalls do not form a comb path into EX.
// PARAMETERS
//  XLEN       32  datapath width: ALU result, store data, branch target
//  REG_AW     5   register-file write-address width
//  RES_SEL_W  1   result-mux select width (1 = ALU/mem; 2 adds PC+4 and imm)
//  CNT_W      16  performance-counter width (used only with EX_MEM_PERF_CNT_EN)
// PORTS
//  clk                  in   1          rising-edge clock
//  rst                  in   1          synchronous, active-high reset
//  flush                in   1          kill all held entries (branch taken / trap)
//  in_valid_E           in   1          EX presents a valid payload
//  in_ready_E           out  1          stage can accept; registered
//  alu_zero_E           in   1          ALU zero flag
//  alu_result_E         in   XLEN       ALU result / memory address
//  rf_srcB_E            in   XLEN       store data
//  rf_wa_E              in   REG_AW     destination register
//  pc_branch_E          in   XLEN       branch target
//  ctrl_rf_we_E         in   1          register-file write enable
//  ctrl_dm_we_E         in   1          data-memory write enable
//  ctrl_result_E        in   RES_SEL_W  write-back result select
//  out_valid_M          out  1          MEM-side payload valid
//  out_ready_M          in   1          MEM consumes payload this cycle
//  alu_zero_M..ctrl_result_M  out  as _E  held payload (head entry)
//  stall_cnt, bubble_cnt  out  CNT_W    only with EX_MEM_PERF_CNT_EN
// BEHAVIOUR
//  Storage: head register H (drives outputs) and skid register S; valid bits vH, vS.
//  States: EMPTY (vH=0,vS=0), ONE (vH=1,vS=0), FULL (vH=1,vS=1). in_ready_E = ~vS, registered.
//  accept = in_valid_E & in_ready_E; pop = out_valid_M & out_ready_M; out_valid_M = vH.
//  EMPTY: accept -> H<=in, ONE. Latency 1 cycle in->out.
//  ONE:   accept&pop -> H<=in, stay ONE; accept&~pop -> S<=in, FULL; pop&~accept -> EMPTY.
//  FULL:  pop -> H<=S, vS<=0, ONE; no accept possible (in_ready_E=0).
//  Order is strictly FIFO. No payload is dropped or duplicated without flush.
//  Throughput: 1 payload/cycle while out_ready_M=1.
//  flush (synchronous): next cycle vH=vS=0, in_ready_E=1. Flush beats accept in the same cycle; the input is dropped.
//  Payload data is not cleared on flush.
//  Write enables are qualified: ctrl_rf_we_M = H.rf_we & vH; ctrl_dm_we_M = H.dm_we & vH.
//  A bubble therefore never writes state.
//  rst: all outputs 0 (payload, valids, counters). in_ready_E=1 from the first cycle after rst deasserts.
//  rst mid-transfer discards H and S. rst has priority over flush.
//  Payload fields are not valid-gated, except the write enables; they hold their last value while vH=0.
// CONFIGURATION
//  EX_MEM_PERF_CNT_EN defined: stall_cnt and bubble_cnt ports are present.
//  stall_cnt +1 each cycle with out_valid_M & ~out_ready_M. bubble_cnt +1 each cycle with ~out_valid_M.
//  Both saturate at 2^CNT_W-1. Both clear on rst only, not on flush.
//  Undefined: the ports and counters are absent. Remaining behaviour is identical.
// STRUCTURE
//  Package riscv_pipe_pkg:
//   - typedef ex_mem_payload_t: packed struct of all _E payload fields.
//   - RES_SEL_ALU / RES_SEL_MEM constants.
//   - localparam EX_MEM_PAYLOAD_W.
//  Sub-module pipe_skid_buf #(W): generic 2-entry skid on a packed vector, owning vH/vS and handshake.
//  Wrapper ex_mem_skid_reg packs and unpacks the struct, applies write-enable qualification, and holds the counters.
// TESTING
//  1. rst 1 cycle, then idle -> out_valid_M=0, all outputs 0, in_ready_E=1, ctrl_dm_we_M=0.
//  2. Stream alu_result 1..8, out_ready_M=1 -> 1..8 out in order, one per cycle, 1-cycle latency, in_ready_E stays 1.
//  3. Send A,B; out_ready_M=0 for 3 cycles:
//     - B lands in S, in_ready_E=0 next cycle, outputs hold A.
//     - Release -> A then B, no loss. stall_cnt=3 when EX_MEM_PERF_CNT_EN.
//  4. FULL with dm_we=1 in H; flush=1 with in_valid_E=1 ->
//     - next cycle out_valid_M=0, ctrl_dm_we_M=0, ctrl_rf_we_M=0, in_ready_E=1.
//     - The flushed-cycle input never appears.
//  5. rst asserted while FULL and stalled -> next cycle all outputs 0; a later input C emerges alone after 1 cycle.
//  6. Idle CNT_W=4 bench, 20 cycles with no input -> bubble_cnt saturates at 15.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared EX/MEM payload types and constants
package riscv_pipe_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int REG_AW_DEF    = 5;
  localparam int RES_SEL_W_DEF = 1;

  localparam logic [RES_SEL_W_DEF-1:0] RES_SEL_ALU = 1'b0;
  localparam logic [RES_SEL_W_DEF-1:0] RES_SEL_MEM = 1'b1;

  typedef struct packed {
    logic                     alu_zero;
    logic [XLEN_DEF-1:0]      alu_result;
    logic [XLEN_DEF-1:0]      rf_srcB;
    logic [REG_AW_DEF-1:0]    rf_wa;
    logic [XLEN_DEF-1:0]      pc_branch;
    logic                     rf_we;
    logic                     dm_we;
    logic [RES_SEL_W_DEF-1:0] result;
  } ex_mem_payload_t;

  localparam int EX_MEM_PAYLOAD_W = $bits(ex_mem_payload_t);

  // Payload width for non-default parameterisations of the stage.
  function automatic int ex_mem_payload_w(int xlen, int reg_aw, int res_sel_w);
    return 3 * xlen + reg_aw + res_sel_w + 3;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic 2-entry skid buffer (head H, skid S) with flush
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] head, skid;
  logic         vh, vs;
  logic         accept, pop;

  // in_ready depends only on the skid flop, so MEM stalls never reach EX combinationally.
  assign in_ready  = ~vs;
  assign out_valid = vh;
  assign out_data  = head;
  assign accept    = in_valid & ~vs;
  assign pop       = vh & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vh   <= 1'b0;
      vs   <= 1'b0;
      head <= '0;
      skid <= '0;
    end else if (flush) begin
      vh <= 1'b0;
      vs <= 1'b0;
    end else if (vs) begin
      if (pop) begin
        head <= skid;
        vs   <= 1'b0;
      end
    end else if (accept && (!vh || pop)) begin
      head <= in_data;
      vh   <= 1'b1;
    end else if (accept) begin
      skid <= in_data;
      vs   <= 1'b1;
    end else if (pop) begin
      vh <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// rtl/ex_mem_skid_reg.sv - EX->MEM stage register with skid buffer and flush
// Optional perf counters with EX_MEM_PERF_CNT_EN.
module ex_mem_skid_reg
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int RES_SEL_W = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid_E,
  output logic                 in_ready_E,
  input  logic                 alu_zero_E,
  input  logic [XLEN-1:0]      alu_result_E,
  input  logic [XLEN-1:0]      rf_srcB_E,
  input  logic [REG_AW-1:0]    rf_wa_E,
  input  logic [XLEN-1:0]      pc_branch_E,
  input  logic                 ctrl_rf_we_E,
  input  logic                 ctrl_dm_we_E,
  input  logic [RES_SEL_W-1:0] ctrl_result_E,
  output logic                 out_valid_M,
  input  logic                 out_ready_M,
  output logic                 alu_zero_M,
  output logic [XLEN-1:0]      alu_result_M,
  output logic [XLEN-1:0]      rf_srcB_M,
  output logic [REG_AW-1:0]    rf_wa_M,
  output logic [XLEN-1:0]      pc_branch_M,
  output logic                 ctrl_rf_we_M,
  output logic                 ctrl_dm_we_M,
`ifdef EX_MEM_PERF_CNT_EN
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt,
`endif
  output logic [RES_SEL_W-1:0] ctrl_result_M
);

  typedef struct packed {
    logic                 alu_zero;
    logic [XLEN-1:0]      alu_result;
    logic [XLEN-1:0]      rf_srcB;
    logic [REG_AW-1:0]    rf_wa;
    logic [XLEN-1:0]      pc_branch;
    logic                 rf_we;
    logic                 dm_we;
    logic [RES_SEL_W-1:0] result;
  } payload_t;

  localparam int PW = ex_mem_payload_w(XLEN, REG_AW, RES_SEL_W);

  payload_t pin, pout;

  assign pin = '{alu_zero: alu_zero_E, alu_result: alu_result_E, rf_srcB: rf_srcB_E,
                 rf_wa: rf_wa_E, pc_branch: pc_branch_E, rf_we: ctrl_rf_we_E,
                 dm_we: ctrl_dm_we_E, result: ctrl_result_E};

  pipe_skid_buf #(.W(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid_E),
    .in_ready  (in_ready_E),
    .in_data   (pin),
    .out_valid (out_valid_M),
    .out_ready (out_ready_M),
    .out_data  (pout)
  );

  assign alu_zero_M    = pout.alu_zero;
  assign alu_result_M  = pout.alu_result;
  assign rf_srcB_M     = pout.rf_srcB;
  assign rf_wa_M       = pout.rf_wa;
  assign pc_branch_M   = pout.pc_branch;
  assign ctrl_result_M = pout.result;
  // A bubble must never write architectural state.
  assign ctrl_rf_we_M  = pout.rf_we & out_valid_M;
  assign ctrl_dm_we_M  = pout.dm_we & out_valid_M;

`ifdef EX_MEM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid_M && !out_ready_M && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!out_valid_M && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// tb/tb_ex_mem_skid_reg.sv - scoreboard bench for ex_mem_skid_reg
module tb_ex_mem_skid_reg;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid_E, in_ready_E, out_valid_M, out_ready_M;
  logic        alu_zero_E, ctrl_rf_we_E, ctrl_dm_we_E;
  logic [31:0] alu_result_E, rf_srcB_E, pc_branch_E;
  logic [4:0]  rf_wa_E;
  logic [0:0]  ctrl_result_E;
  logic        alu_zero_M, ctrl_rf_we_M, ctrl_dm_we_M;
  logic [31:0] alu_result_M, rf_srcB_M, pc_branch_M;
  logic [4:0]  rf_wa_M;
  logic [0:0]  ctrl_result_M;
`ifdef EX_MEM_PERF_CNT_EN
  logic [CW-1:0] stall_cnt, bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] q[$];
  logic [31:0] cur_val;

  always #5 clk = ~clk;

  ex_mem_skid_reg #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid_E(in_valid_E), .in_ready_E(in_ready_E),
    .alu_zero_E(alu_zero_E), .alu_result_E(alu_result_E), .rf_srcB_E(rf_srcB_E),
    .rf_wa_E(rf_wa_E), .pc_branch_E(pc_branch_E), .ctrl_rf_we_E(ctrl_rf_we_E),
    .ctrl_dm_we_E(ctrl_dm_we_E), .ctrl_result_E(ctrl_result_E),
    .out_valid_M(out_valid_M), .out_ready_M(out_ready_M),
    .alu_zero_M(alu_zero_M), .alu_result_M(alu_result_M), .rf_srcB_M(rf_srcB_M),
    .rf_wa_M(rf_wa_M), .pc_branch_M(pc_branch_M), .ctrl_rf_we_M(ctrl_rf_we_M),
    .ctrl_dm_we_M(ctrl_dm_we_M),
`ifdef EX_MEM_PERF_CNT_EN
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
    .ctrl_result_M(ctrl_result_M)
  );

  // Every payload field is derived from the alu_result value so one word identifies an entry.
  function automatic logic [127:0] exp_vec(logic [31:0] v);
    logic [31:0] pcb;
    pcb = v + 32'd100;
    return {23'd0, v[0], v, ~v, v[4:0], pcb, 1'b1, v[1], v[0]};
  endfunction

  function automatic logic [127:0] obs_vec();
    return {23'd0, alu_zero_M, alu_result_M, rf_srcB_M, rf_wa_M, pc_branch_M,
            ctrl_rf_we_M, ctrl_dm_we_M, ctrl_result_M};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] val);
    cur_val       = val;
    in_valid_E    = v;
    alu_result_E  = val;
    alu_zero_E    = val[0];
    rf_srcB_E     = ~val;
    rf_wa_E       = val[4:0];
    pc_branch_E   = val + 32'd100;
    ctrl_rf_we_E  = 1'b1;
    ctrl_dm_we_E  = val[1];
    ctrl_result_E = val[0];
  endtask

  task automatic step();
    logic model_ready;
    logic [31:0] e;
    @(negedge clk);
    if (rst) begin
      q.delete();
    end else begin
      model_ready = (q.size() < 2);
      chk("in_ready", 128'(in_ready_E), 128'(model_ready));
      chk("out_valid", 128'(out_valid_M), 128'(q.size() > 0));
      if (q.size() > 0 && out_ready_M) begin
        e = q.pop_front();
        chk("payload", obs_vec(), exp_vec(e));
      end
      if (flush) q.delete();
      else if (in_valid_E && model_ready) q.push_back(cur_val);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready_M = 1'b0;
    drive(1'b0, 32'd0);
    step();
    rst = 1'b0;
    // Reset state.
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid_M), 128'd0);
    chk("rst_in_ready", 128'(in_ready_E), 128'd1);
    chk("rst_outputs", obs_vec(), 128'd0);
    chk("rst_dm_we", 128'(ctrl_dm_we_M), 128'd0);
    @(posedge clk); #1;

    // Streaming at full throughput.
    out_ready_M = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i));
      step();
    end
    drive(1'b0, 32'd0);
    step();
    chk("stream_drained", 128'(q.size()), 128'd0);

    // Back-pressure: B lands in skid, then both drain in order.
    out_ready_M = 1'b0;
    drive(1'b1, 32'h100); step();
    drive(1'b1, 32'h200); step();
    drive(1'b1, 32'h300); step();
    chk("stall_hold_a", 128'(alu_result_M), 128'h100);
    chk("stall_in_ready", 128'(in_ready_E), 128'd0);
    drive(1'b0, 32'd0); step();
    out_ready_M = 1'b1;
`ifdef EX_MEM_PERF_CNT_EN
    chk("stall_cnt", 128'(stall_cnt), 128'd3);
`endif
    step(); step(); step();
    chk("stall_drained", 128'(q.size()), 128'd0);

    // Flush while FULL with a store in H; flushed-cycle input is dropped.
    out_ready_M = 1'b0;
    drive(1'b1, 32'h402); step();
    drive(1'b1, 32'h406); step();
    flush = 1'b1;
    drive(1'b1, 32'h999); step();
    flush = 1'b0;
    drive(1'b0, 32'd0);
    @(negedge clk);
    chk("flush_out_valid", 128'(out_valid_M), 128'd0);
    chk("flush_dm_we", 128'(ctrl_dm_we_M), 128'd0);
    chk("flush_rf_we", 128'(ctrl_rf_we_M), 128'd0);
    chk("flush_in_ready", 128'(in_ready_E), 128'd1);
    @(posedge clk); #1;
    out_ready_M = 1'b1;
    step(); step();

    // Reset mid-transfer while FULL and stalled.
    out_ready_M = 1'b0;
    drive(1'b1, 32'h51a); step();
    drive(1'b1, 32'h52b); step();
    drive(1'b0, 32'd0);
    rst = 1'b1; step(); rst = 1'b0;
    @(negedge clk);
    chk("rst2_outputs", obs_vec(), 128'd0);
    chk("rst2_out_valid", 128'(out_valid_M), 128'd0);
    chk("rst2_in_ready", 128'(in_ready_E), 128'd1);
    @(posedge clk); #1;
    out_ready_M = 1'b1;
    drive(1'b1, 32'hc0c); step();
    chk("c_alone_valid", 128'(out_valid_M), 128'd1);
    chk("c_alone_data", 128'(alu_result_M), 128'hc0c);
    drive(1'b0, 32'd0);
    step(); step();
    chk("final_drained", 128'(q.size()), 128'd0);

`ifdef EX_MEM_PERF_CNT_EN
    for (int i = 0; i < 20; i++) step();
    chk("bubble_sat", 128'(bubble_cnt), 128'd15);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
